// File: rtl/aud_pwm_pkg.sv
// Register map and bit positions shared by the
// aud_pwm_apb_mc peripheral and its channel slices.
package aud_pwm_pkg;

  localparam logic [7:0] CTRL_OFF         = 8'h00;
  localparam logic [7:0] STATUS_OFF       = 8'h04;
  localparam logic [7:0] PRESCALE_OFF     = 8'h08;
  localparam logic [7:0] UNDERRUN_CLR_OFF = 8'h0C;
  localparam logic [7:0] DATA_BASE        = 8'h10;
  localparam logic [7:0] LEVEL_BASE       = 8'h40;
  localparam logic [7:0] IRQ_CFG_OFF      = 8'h18;

  localparam int CTRL_EN_LSB   = 0;
  localparam int CTRL_SRST_BIT = 16;

  localparam int STATUS_EMPTY_LSB = 0;
  localparam int STATUS_UNDR_LSB  = 8;
  localparam int STATUS_FULL_LSB  = 16;

  localparam int IRQ_EN_BIT = 8;

endpackage

// File: rtl/aud_pwm_chan.sv
// One PWM channel: sample FIFO, period counter,
// duty register, sticky underrun flag, output flop.
module aud_pwm_chan
  import aud_pwm_pkg::*;
#(
  parameter int SAMPLE_W   = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                pclk_i,
  input  logic                presetn_i,
  input  logic                en,
  input  logic                tick,
  input  logic                flush,
  input  logic                push,
  input  logic [SAMPLE_W-1:0] push_data,
  input  logic                uclr,
  output logic                pwm,
  output logic [LW-1:0]       level,
  output logic                empty,
  output logic                full,
  output logic                underrun,
  output logic                can_push
);

  localparam logic [SAMPLE_W-1:0] CNT_MAX = '1;

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]         wptr;
  logic [AW:0]         rptr;
  logic [SAMPLE_W-1:0] cnt;
  logic [SAMPLE_W-1:0] duty;
  logic                en_q;
  logic                rise;
  logic                step;
  logic                bound;
  logic                pop;
  logic                push_ok;
  logic                set_und;

  assign level    = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (level == LW'(FIFO_DEPTH));
  assign rise     = en & ~en_q;
  assign step     = en & tick & ~rise & ~flush;
  assign bound    = step & (cnt == CNT_MAX);
  assign pop      = bound & ~empty;
  assign set_und  = bound & empty;
  // A pop in this cycle frees a slot for a push
  assign can_push = ~full | pop;
  assign push_ok  = push & can_push & ~flush;

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      cnt      <= '0;
      duty     <= '0;
      underrun <= 1'b0;
    end else if (flush) begin
      cnt      <= '0;
      duty     <= '0;
      underrun <= 1'b0;
    end else begin
      if (rise) begin
        cnt  <= '0;
        duty <= '0;
      end else if (step) begin
        cnt <= cnt + 1'b1;
        if (pop) duty <= mem[rptr[AW-1:0]];
      end
      if (set_und)   underrun <= 1'b1;
      else if (uclr) underrun <= 1'b0;
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      en_q <= 1'b0;
      pwm  <= 1'b0;
    end else begin
      en_q <= en;
      pwm  <= en & (cnt < duty);
    end
  end

endmodule

// File: rtl/aud_pwm_apb_mc.sv
// APB multi-channel audio PWM: decode, CTRL, prescaler.
// Optional IRQ_CFG register and irq_o under AUD_PWM_IRQ_EN.
module aud_pwm_apb_mc
  import aud_pwm_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_W   = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              pclk_i,
  input  logic              presetn_i,
  input  logic [31:0]       paddr_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [3:0][7:0]   pwdata_i,
  input  logic [3:0]        pstrb_i,
  output logic              pready_o,
  output logic [31:0]       prdata_o,
  output logic              pslverr_o,
`ifdef AUD_PWM_IRQ_EN
  output logic              irq_o,
`endif
  output logic [NUM_CH-1:0] aud_pwm_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       wdata;
  logic [7:0]        a;
  logic              hi_ok;
  logic              access;
  logic              ctrl_hit, stat_hit, pre_hit;
  logic              uclr_hit, irq_hit;
  logic [NUM_CH-1:0] data_sel, lvl_sel;
  logic              map_wr, map_rd, full_err;
  logic              err, wr_ok;

  logic [NUM_CH-1:0] ctrl_en;
  logic              srst_q;
  logic [15:0]       prescale;
  logic [15:0]       psc;
  logic              any_en, tick;

  logic [NUM_CH-1:0] ch_empty, ch_full, ch_und, ch_can;
  logic [LW-1:0]     ch_level [NUM_CH];

  logic              unused_ok;

  assign wdata     = pwdata_i;
  assign a         = paddr_i[7:0];
  assign hi_ok     = ~|paddr_i[31:8];
  assign access    = psel_i & penable_i;
  assign pready_o  = psel_i;
  assign unused_ok = ^{wdata, pstrb_i};

  assign ctrl_hit = hi_ok & (a == CTRL_OFF);
  assign stat_hit = hi_ok & (a == STATUS_OFF);
  assign pre_hit  = hi_ok & (a == PRESCALE_OFF);
  assign uclr_hit = hi_ok & (a == UNDERRUN_CLR_OFF);
`ifdef AUD_PWM_IRQ_EN
  assign irq_hit  = hi_ok & (a == IRQ_CFG_OFF);
`else
  assign irq_hit  = 1'b0;
`endif

  always_comb begin
    data_sel = '0;
    lvl_sel  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hi_ok && a == DATA_BASE + 8'(4 * c))
        data_sel[c] = 1'b1;
      if (hi_ok && a == LEVEL_BASE + 8'(4 * c))
        lvl_sel[c] = 1'b1;
    end
  end

  assign map_wr   = ctrl_hit | pre_hit | uclr_hit
                  | (|data_sel) | irq_hit;
  assign map_rd   = ctrl_hit | stat_hit | pre_hit
                  | (|lvl_sel) | irq_hit;
  assign full_err = |(data_sel & ~ch_can);
  assign err      = access & (pwrite_i
                  ? (~map_wr | full_err) : ~map_rd);
  assign wr_ok    = access & pwrite_i & ~err;
  assign pslverr_o = err;

  assign any_en = |ctrl_en;
  assign tick   = any_en & (psc >= prescale);

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      ctrl_en  <= '0;
      srst_q   <= 1'b0;
      prescale <= '0;
      psc      <= '0;
    end else begin
      srst_q <= wr_ok & ctrl_hit & pstrb_i[2]
              & wdata[CTRL_SRST_BIT];
      if (wr_ok & ctrl_hit & pstrb_i[0])
        ctrl_en <= wdata[CTRL_EN_LSB +: NUM_CH];
      if (wr_ok & pre_hit & pstrb_i[0])
        prescale[7:0] <= wdata[7:0];
      if (wr_ok & pre_hit & pstrb_i[1])
        prescale[15:8] <= wdata[15:8];
      if (srst_q | ~any_en) psc <= '0;
      else if (tick)        psc <= '0;
      else                  psc <= psc + 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    aud_pwm_chan #(
      .SAMPLE_W   (SAMPLE_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chan (
      .pclk_i    (pclk_i),
      .presetn_i (presetn_i),
      .en        (ctrl_en[c]),
      .tick      (tick),
      .flush     (srst_q),
      .push      (wr_ok & data_sel[c] & ~srst_q),
      .push_data (wdata[SAMPLE_W-1:0]),
      .uclr      (wr_ok & uclr_hit & pstrb_i[0]
                  & wdata[c]),
      .pwm       (aud_pwm_o[c]),
      .level     (ch_level[c]),
      .empty     (ch_empty[c]),
      .full      (ch_full[c]),
      .underrun  (ch_und[c]),
      .can_push  (ch_can[c])
    );
  end

`ifdef AUD_PWM_IRQ_EN
  logic [8:0] irq_cfg;
  logic       irq_any;

  always_comb begin
    irq_any = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ctrl_en[c] && (ch_und[c] ||
          int'(ch_level[c]) <= int'(irq_cfg[7:0])))
        irq_any = 1'b1;
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      irq_cfg <= '0;
      irq_o   <= 1'b0;
    end else begin
      if (wr_ok & irq_hit & pstrb_i[0])
        irq_cfg[7:0] <= wdata[7:0];
      if (wr_ok & irq_hit & pstrb_i[1])
        irq_cfg[8] <= wdata[IRQ_EN_BIT];
      irq_o <= irq_cfg[IRQ_EN_BIT] & irq_any;
    end
  end
`endif

  always_comb begin
    prdata_o = '0;
    if (access && !pwrite_i) begin
      if (ctrl_hit) begin
        prdata_o[CTRL_EN_LSB +: NUM_CH] = ctrl_en;
        prdata_o[CTRL_SRST_BIT]          = srst_q;
      end else if (stat_hit) begin
        prdata_o[STATUS_EMPTY_LSB +: NUM_CH] = ch_empty;
        prdata_o[STATUS_UNDR_LSB +: NUM_CH]  = ch_und;
        prdata_o[STATUS_FULL_LSB +: NUM_CH]  = ch_full;
      end else if (pre_hit) begin
        prdata_o[15:0] = prescale;
`ifdef AUD_PWM_IRQ_EN
      end else if (irq_hit) begin
        prdata_o[8:0] = irq_cfg;
`endif
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (lvl_sel[c]) prdata_o[LW-1:0] = ch_level[c];
        end
      end
    end
  end

endmodule
